// File: rtl/ex_seq.sv
// ex_seq: multi-cycle execute stage (ALU, move/shift, branch) between decode and writeback handshakes.
// Build macro EX_ITER_SHIFT_EN swaps the barrel shifter for a 1-bit-per-cycle shifter (SHIFT state).
module ex_seq #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              special_enc,
    input  logic [1:0]        first_ld,
    input  logic [2:0]        alu_oc,
    input  logic [3:0]        b_cond,
    input  logic [2:0]        dest_reg,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic [DATA_W-1:0] imm,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    input  logic              out_ready,
    output logic [2:0]        out_dest,
    output logic              out_wr_en,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target,
    output logic [3:0]        flags,
    output logic              busy
);
    localparam int SH_W = $clog2(DATA_W);
    localparam int HALF = DATA_W / 2;

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, SHIFT = 2'd2, RESP = 2'd3} state_t;
    state_t state_q, state_d;

    logic              enc_q, enc_d;
    logic [1:0]        fld_q, fld_d;
    logic [2:0]        oc_q, oc_d;
    logic [3:0]        cond_q, cond_d;
    logic [2:0]        dest_q, dest_d;
    logic [DATA_W-1:0] op1_q, op1_d, opb_q, opb_d, imm_q, imm_d;
    logic [DATA_W-1:0] res_q, res_d, tgt_q, tgt_d;
    logic              wr_q, wr_d, taken_q, taken_d;
    logic [3:0]        flags_q, flags_d;

    logic [DATA_W:0]   add_s, sub_s;
    logic [DATA_W-1:0] ex_res_s, ex_tgt_s;
    logic              ex_wr_s, ex_taken_s, go_shift_s;
    logic [3:0]        ex_flags_s;
    logic [SH_W-1:0]   amt_s;

`ifdef EX_ITER_SHIFT_EN
    logic [DATA_W-1:0] shv_q, shv_d, shv_nx_s;
    logic [SH_W-1:0]   cnt_q, cnt_d;
    assign go_shift_s = !enc_q && (fld_q == 2'b00) && ((oc_q == 3'd4) || (oc_q == 3'd5)) && (amt_s != '0);
    assign shv_nx_s   = (oc_q == 3'd4) ? {shv_q[DATA_W-2:0], 1'b0} : {1'b0, shv_q[DATA_W-1:1]};
`else
    assign go_shift_s = 1'b0;
`endif

    // Condition codes evaluated against flags = {N,Z,C,V}.
    function automatic logic cond_hold(input logic [3:0] c, input logic [3:0] f);
        logic n_s, z_s, c_s, v_s;
        n_s = f[3];
        z_s = f[2];
        c_s = f[1];
        v_s = f[0];
        case (c)
            4'd0:    cond_hold = z_s;
            4'd1:    cond_hold = !z_s;
            4'd2:    cond_hold = c_s;
            4'd3:    cond_hold = !c_s;
            4'd4:    cond_hold = n_s;
            4'd5:    cond_hold = !n_s;
            4'd6:    cond_hold = v_s;
            4'd7:    cond_hold = !v_s;
            4'd8:    cond_hold = (n_s == v_s);
            4'd9:    cond_hold = (n_s != v_s);
            4'd10:   cond_hold = !z_s && (n_s == v_s);
            4'd11:   cond_hold = z_s || (n_s != v_s);
            4'd14:   cond_hold = 1'b1;
            default: cond_hold = 1'b0;
        endcase
    endfunction

    assign amt_s = opb_q[SH_W-1:0];
    assign add_s = {1'b0, op1_q} + {1'b0, opb_q};
    assign sub_s = {1'b0, op1_q} - {1'b0, opb_q};

    // Single-cycle execute result computed from the latched instruction.
    always_comb begin
        ex_res_s   = '0;
        ex_wr_s    = 1'b0;
        ex_taken_s = 1'b0;
        ex_tgt_s   = '0;
        ex_flags_s = flags_q;
        if (enc_q) begin
            ex_wr_s = 1'b1;
            case (oc_q)
                3'd1: begin
                    ex_res_s      = add_s[DATA_W-1:0];
                    ex_flags_s[1] = add_s[DATA_W];
                    ex_flags_s[0] = (op1_q[DATA_W-1] == opb_q[DATA_W-1]) && (add_s[DATA_W-1] != op1_q[DATA_W-1]);
                end
                3'd2: begin
                    ex_res_s      = sub_s[DATA_W-1:0];
                    ex_flags_s[1] = !sub_s[DATA_W];
                    ex_flags_s[0] = (op1_q[DATA_W-1] != opb_q[DATA_W-1]) && (sub_s[DATA_W-1] != op1_q[DATA_W-1]);
                end
                3'd3:    ex_res_s = op1_q & opb_q;
                3'd4:    ex_res_s = op1_q | opb_q;
                3'd5:    ex_res_s = op1_q ^ opb_q;
                3'd6:    ex_res_s = ~op1_q;
                default: ex_wr_s  = 1'b0;
            endcase
            if (ex_wr_s) begin
                ex_flags_s[3] = ex_res_s[DATA_W-1];
                ex_flags_s[2] = (ex_res_s == '0);
            end else begin
                ex_flags_s = flags_q;
            end
        end else if (fld_q == 2'b00) begin
            ex_wr_s = 1'b1;
            case (oc_q)
                3'd0: ex_res_s = opb_q;
                3'd1: ex_res_s = {opb_q[HALF-1:0], op1_q[HALF-1:0]};
                3'd2: ex_res_s = '0;
                3'd3: ex_res_s = '1;
`ifdef EX_ITER_SHIFT_EN
                3'd4, 3'd5: ex_res_s = op1_q;
`else
                3'd4: ex_res_s = op1_q << amt_s;
                3'd5: ex_res_s = op1_q >> amt_s;
`endif
                default: ex_wr_s = 1'b0;
            endcase
        end else begin
            case (oc_q)
                3'd0: begin
                    ex_taken_s = 1'b1;
                    ex_tgt_s   = imm_q;
                end
                3'd1: begin
                    ex_taken_s = cond_hold(cond_q, flags_q);
                    ex_tgt_s   = imm_q;
                end
                3'd2: begin
                    ex_taken_s = 1'b1;
                    ex_tgt_s   = op1_q;
                end
                default: ex_taken_s = 1'b0;
            endcase
        end
    end

    // Sequencer: accept in IDLE, execute, optional iterative shift, hold response until out_ready.
    always_comb begin
        state_d = state_q;
        enc_d   = enc_q;
        fld_d   = fld_q;
        oc_d    = oc_q;
        cond_d  = cond_q;
        dest_d  = dest_q;
        op1_d   = op1_q;
        opb_d   = opb_q;
        imm_d   = imm_q;
        res_d   = res_q;
        wr_d    = wr_q;
        taken_d = taken_q;
        tgt_d   = tgt_q;
        flags_d = flags_q;
`ifdef EX_ITER_SHIFT_EN
        shv_d   = shv_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = EXEC;
                    enc_d   = special_enc;
                    fld_d   = first_ld;
                    oc_d    = alu_oc;
                    cond_d  = b_cond;
                    dest_d  = dest_reg;
                    op1_d   = op1;
                    opb_d   = first_ld[0] ? op2 : imm;
                    imm_d   = imm;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (go_shift_s) begin
                    state_d = SHIFT;
`ifdef EX_ITER_SHIFT_EN
                    shv_d   = op1_q;
                    cnt_d   = amt_s;
`endif
                end else begin
                    state_d = RESP;
                    res_d   = ex_res_s;
                    wr_d    = ex_wr_s;
                    taken_d = ex_taken_s;
                    tgt_d   = ex_tgt_s;
                    flags_d = ex_flags_s;
                end
            end
            SHIFT: begin
`ifdef EX_ITER_SHIFT_EN
                shv_d = shv_nx_s;
                cnt_d = cnt_q - SH_W'(1);
                if (cnt_q == SH_W'(1)) begin
                    state_d = RESP;
                    res_d   = shv_nx_s;
                    wr_d    = 1'b1;
                    taken_d = 1'b0;
                    tgt_d   = '0;
                end else begin
                    state_d = SHIFT;
                end
`else
                state_d = IDLE;
`endif
            end
            RESP: begin
                if (out_ready) begin
                    state_d = IDLE;
                    wr_d    = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            enc_q   <= 1'b0;
            fld_q   <= 2'b00;
            oc_q    <= 3'd0;
            cond_q  <= 4'd0;
            dest_q  <= 3'd0;
            op1_q   <= '0;
            opb_q   <= '0;
            imm_q   <= '0;
            res_q   <= '0;
            wr_q    <= 1'b0;
            taken_q <= 1'b0;
            tgt_q   <= '0;
            flags_q <= 4'd0;
`ifdef EX_ITER_SHIFT_EN
            shv_q   <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            enc_q   <= enc_d;
            fld_q   <= fld_d;
            oc_q    <= oc_d;
            cond_q  <= cond_d;
            dest_q  <= dest_d;
            op1_q   <= op1_d;
            opb_q   <= opb_d;
            imm_q   <= imm_d;
            res_q   <= res_d;
            wr_q    <= wr_d;
            taken_q <= taken_d;
            tgt_q   <= tgt_d;
            flags_q <= flags_d;
`ifdef EX_ITER_SHIFT_EN
            shv_q   <= shv_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign out_valid     = (state_q == RESP);
    assign out_result    = res_q;
    assign out_dest      = dest_q;
    assign out_wr_en     = wr_q;
    assign branch_taken  = taken_q;
    assign branch_target = tgt_q;
    assign flags         = flags_q;
endmodule

// File: tb/tb_ex_seq.sv
// Randomized + directed bench for ex_seq against an arithmetic reference model of the instruction set.
module tb_ex_seq;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, special_enc, out_valid, out_ready, out_wr_en, branch_taken, busy;
    logic [1:0]  first_ld;
    logic [2:0]  alu_oc, dest_reg, out_dest;
    logic [3:0]  b_cond, flags;
    logic [15:0] op1, op2, imm, out_result, branch_target;

    int vectors = 0;
    int miscompares = 0;

    bit          m_n, m_z, m_c, m_v;
    logic [15:0] exp_res, exp_tg;
    bit          exp_wr, exp_tk;
    int          exp_lat;

    ex_seq #(.DATA_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .special_enc(special_enc), .first_ld(first_ld), .alu_oc(alu_oc), .b_cond(b_cond),
        .dest_reg(dest_reg), .op1(op1), .op2(op2), .imm(imm),
        .out_valid(out_valid), .out_result(out_result), .out_ready(out_ready),
        .out_dest(out_dest), .out_wr_en(out_wr_en), .branch_taken(branch_taken),
        .branch_target(branch_target), .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_ok(input logic [3:0] c);
        case (c)
            4'd0:  return m_z;
            4'd1:  return !m_z;
            4'd2:  return m_c;
            4'd3:  return !m_c;
            4'd4:  return m_n;
            4'd5:  return !m_n;
            4'd6:  return m_v;
            4'd7:  return !m_v;
            4'd8:  return m_n == m_v;
            4'd9:  return m_n != m_v;
            4'd10: return !m_z && (m_n == m_v);
            4'd11: return m_z || (m_n != m_v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model(input logic se, input logic [1:0] fl, input logic [2:0] oc, input logic [3:0] bc,
                         input logic [15:0] a, input logic [15:0] o2, input logic [15:0] im);
        logic [15:0] b;
        longint ua, ub, wide;
        int sa, sb, sd;
        b = fl[0] ? o2 : im;
        ua = longint'(a);
        ub = longint'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        exp_res = 16'h0; exp_wr = 1'b0; exp_tk = 1'b0; exp_tg = 16'h0; exp_lat = 2;
        if (se) begin
            exp_wr = (oc >= 3'd1) && (oc <= 3'd6);
            case (oc)
                3'd1: begin
                    wide = ua + ub; exp_res = 16'(wide % 65536);
                    m_c = (wide > 65535); sd = sa + sb; m_v = (sd > 32767) || (sd < -32768);
                end
                3'd2: begin
                    wide = ua - ub; if (wide < 0) wide = wide + 65536; exp_res = 16'(wide);
                    m_c = (ua >= ub); sd = sa - sb; m_v = (sd > 32767) || (sd < -32768);
                end
                3'd3: exp_res = a & b;
                3'd4: exp_res = a | b;
                3'd5: exp_res = a ^ b;
                3'd6: exp_res = ~a;
                default: exp_res = 16'h0;
            endcase
            if (exp_wr) begin
                m_n = exp_res[15];
                m_z = (exp_res == 16'h0);
            end
        end else if (fl == 2'b00) begin
            exp_wr = (oc <= 3'd5);
            case (oc)
                3'd0: exp_res = b;
                3'd1: exp_res = {b[7:0], a[7:0]};
                3'd3: exp_res = 16'hFFFF;
                3'd4: exp_res = 16'((ua * (longint'(1) << b[3:0])) % 65536);
                3'd5: exp_res = 16'(ua / (longint'(1) << b[3:0]));
                default: exp_res = 16'h0;
            endcase
`ifdef EX_ITER_SHIFT_EN
            if (oc == 3'd4 || oc == 3'd5) exp_lat = 2 + int'(b[3:0]);
`endif
        end else begin
            case (oc)
                3'd0: begin exp_tk = 1'b1; exp_tg = im; end
                3'd1: begin exp_tk = cond_ok(bc); exp_tg = im; end
                3'd2: begin exp_tk = 1'b1; exp_tg = a; end
                default: exp_tk = 1'b0;
            endcase
        end
    endtask

    task automatic scramble();
        special_enc = 1'($urandom); first_ld = 2'($urandom); alu_oc = 3'($urandom);
        b_cond = 4'($urandom); dest_reg = 3'($urandom);
        op1 = 16'($urandom); op2 = 16'($urandom); imm = 16'($urandom);
    endtask

    task automatic check_resp(input logic [2:0] dr);
        check("valid", out_valid, 32'd1);
        check("in_ready_resp", in_ready, 32'd0);
        check("busy_resp", busy, 32'd1);
        check("result", out_result, exp_res);
        check("wr_en", out_wr_en, exp_wr);
        check("taken", branch_taken, exp_tk);
        if (exp_tk) check("target", branch_target, exp_tg);
        check("dest", out_dest, dr);
        check("flags", flags, {m_n, m_z, m_c, m_v});
    endtask

    // Issue one instruction, wait for RESP (bounded), compare latency and outputs; stays in RESP.
    task automatic run_op(input logic se, input logic [1:0] fl, input logic [2:0] oc, input logic [3:0] bc,
                          input logic [2:0] dr, input logic [15:0] a, input logic [15:0] o2, input logic [15:0] im);
        int lat;
        model(se, fl, oc, bc, a, o2, im);
        check("in_ready_idle", in_ready, 32'd1);
        special_enc = se; first_ld = fl; alu_oc = oc; b_cond = bc; dest_reg = dr;
        op1 = a; op2 = o2; imm = im; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            check("wr_en_not_resp", out_wr_en, 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        @(negedge clk);
        check_resp(dr);
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_valid", out_valid, 32'd0);
        check("idle_wr_en", out_wr_en, 32'd0);
        check("idle_hold", out_result, exp_res);
        check("idle_ready", in_ready, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        scramble();
        {m_n, m_z, m_c, m_v} = 4'b0000;
        #1;
        check("rst_valid", out_valid, 32'd0);
        check("rst_flags", flags, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_result", out_result, 32'd0);
        check("rst_target", branch_target, 32'd0);
        check("rst_dest", out_dest, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", in_ready, 32'd1);
        @(posedge clk); #1;

        // ADD imm overflow
        run_op(1'b1, 2'b00, 3'd1, 4'd0, 3'd2, 16'h7FFF, 16'h1111, 16'h0001);
        check("add_result_const", out_result, 32'h8000);
        check("add_flags_const", flags, 32'h9);
        finish_op();

        // SUB reg equal operands then Bcond EQ
        run_op(1'b1, 2'b01, 3'd2, 4'd0, 3'd3, 16'h0005, 16'h0005, 16'hABCD);
        check("sub_flags_const", flags, 32'h6);
        finish_op();
        run_op(1'b0, 2'b10, 3'd1, 4'd0, 3'd1, 16'h1234, 16'h0000, 16'h0040);
        check("bcond_target_const", branch_target, 32'h0040);
        finish_op();

        // LSL by 15, then backpressure with a pending request
        run_op(1'b0, 2'b00, 3'd4, 4'd0, 3'd5, 16'h0001, 16'h0000, 16'd15);
        check("lsl_result_const", out_result, 32'h8000);
        scramble();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_resp(3'd5);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("bp_idle_valid", out_valid, 32'd0);
        check("bp_idle_ready", in_ready, 32'd1);
        @(posedge clk); #1;
        check("bp_no_accept", busy, 32'd0);

        // Reset in the middle of a long shift
        special_enc = 1'b0; first_ld = 2'b00; alu_oc = 3'd4; op1 = 16'h0001; imm = 16'd15; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_busy", busy, 32'd1);
        rst = 1'b1;
        #1;
        {m_n, m_z, m_c, m_v} = 4'b0000;
        check("midrst_valid", out_valid, 32'd0);
        check("midrst_flags", flags, 32'd0);
        check("midrst_busy", busy, 32'd0);
        check("midrst_wr_en", out_wr_en, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(1'b0, 2'b00, 3'd0, 4'd0, 3'd7, 16'hFFFF, 16'h0000, 16'h1234);
        check("mov_result_const", out_result, 32'h1234);
        finish_op();

        // Random instruction stream
        for (int n = 0; n < 150; n++) begin
            run_op(1'($urandom), 2'($urandom), 3'($urandom), 4'($urandom), 3'($urandom),
                   16'($urandom), 16'($urandom), 16'($urandom));
            for (int w = $urandom_range(0, 2); w > 0; w--) begin
                @(posedge clk); #1;
                check("hold_valid", out_valid, 32'd1);
                check("hold_result", out_result, exp_res);
            end
            finish_op();
            for (int w = $urandom_range(0, 1); w > 0; w--) begin
                @(posedge clk); #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
